// File: rtl/ddfs_seq.sv
// DDFS sequencer: phase accumulator driving an external registered sine ROM,
// with amplitude scaling of the returned word into one PCM sample per accepted tick.
module ddfs_seq #(
  parameter int PW         = 30,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  sample_tick,
  input  logic [PW-1:0]         fccw,
  input  logic [PW-1:0]         focw,
  input  logic [DATA_WIDTH-1:0] amp,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [DATA_WIDTH-1:0] pcm_out,
  output logic                  pcm_valid,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic signed [2*DATA_WIDTH-1:0] SAT_HI =
    {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  // Handshake: sample_tick is a one-cycle strobe with no backpressure; it is
  // accepted only in RUN, and each accepted tick yields exactly one pcm_valid
  // pulse two cycles later unless reset intervenes.

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]            inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] pcm_q, pcm_d;
  logic                  pcm_valid_q, pcm_valid_d;

  logic                         tick_acc;
  logic [PW-1:0]                offset_sum;
  logic [PW-1:0]                offset_shift;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] shifted;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rom_addr_d   = rom_addr_q;
    pcm_d        = pcm_q;
    tick_acc     = (state_q == ST_RUN) && sample_tick;
    inflight_d   = {inflight_q[0], tick_acc};
    pcm_valid_d  = inflight_q[1];
    offset_sum   = phase_q + focw;
    offset_shift = offset_sum >> (PW - ADDR_WIDTH);
    prod         = $signed(rom_dout) * $signed(amp);
    shifted      = prod >>> (DATA_WIDTH - 1);

    case (state_q)
      ST_IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          state_d = ST_RUN;
          phase_d = '0;
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (inflight_q == 2'b00) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick_acc) begin
      rom_addr_d = ADDR_WIDTH'(offset_shift);
      phase_d    = phase_q + fccw;
    end

    // Only full-scale negative squared exceeds the positive range
    if (inflight_q[1]) begin
      if (shifted > SAT_HI) pcm_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else                  pcm_d = DATA_WIDTH'(shifted);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      rom_addr_q  <= '0;
      inflight_q  <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rom_addr_q  <= rom_addr_d;
      inflight_q  <= inflight_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pcm_out   = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ddfs_seq.sv
// Directed bench for ddfs_seq with a small registered ROM model whose
// entries and scaled outputs are hand-computed.
module tb_ddfs_seq;

  localparam int PW = 30;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, stop, sample_tick;
  logic [PW-1:0] fccw, focw;
  logic [DW-1:0] amp, rom_dout, pcm_out;
  logic [AW-1:0] rom_addr;
  logic          pcm_valid, busy;
  logic [1:0]    state_dbg;
  logic          force_rom;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_addr3 [5];
  logic [15:0] exp_pcm3  [5];

  ddfs_seq #(.PW(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .sample_tick(sample_tick), .fccw(fccw), .focw(focw), .amp(amp),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .pcm_out(pcm_out),
    .pcm_valid(pcm_valid), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ROM model: a few true sine entries, arbitrary distinct words elsewhere
  function automatic logic [15:0] rom_fn(input logic [7:0] a);
    case (a)
      8'd0:    rom_fn = 16'h0000;
      8'd1:    rom_fn = 16'h0324;
      8'd64:   rom_fn = 16'h7FFF;
      8'd128:  rom_fn = 16'h0000;
      8'd192:  rom_fn = 16'h8001;
      default: rom_fn = 16'h1000 | {8'h00, a};
    endcase
  endfunction

  always @(posedge clk) rom_dout <= force_rom ? 16'h8000 : rom_fn(rom_addr);

  // driver: advance one edge, then sample 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_addr3[0] = 16'd0;   exp_addr3[1] = 16'd192; exp_addr3[2] = 16'd128;
    exp_addr3[3] = 16'd64;  exp_addr3[4] = 16'd0;
    exp_pcm3[0]  = 16'h0000; exp_pcm3[1] = 16'h8001; exp_pcm3[2] = 16'h0000;
    exp_pcm3[3]  = 16'h7FFE; exp_pcm3[4] = 16'h0000;

    reset = 1'b1; start = 1'b0; stop = 1'b0; sample_tick = 1'b0;
    fccw = '0; focw = '0; amp = 16'h7FFF; force_rom = 1'b0;
    #2;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_addr",  32'(rom_addr),  32'd0);
    chk("rst_pcm",   32'(pcm_out),   32'd0);
    chk("rst_valid", 32'(pcm_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);

    // 1: tick every cycle, fccw = 2^22
    start = 1'b1; cyc(); start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    sample_tick = 1'b1; fccw = 30'd1 << 22; focw = '0; amp = 16'h7FFF;
    cyc(); chk("t1_addr0", 32'(rom_addr), 32'd0); chk("t1_v0", 32'(pcm_valid), 32'd0);
    cyc(); chk("t1_addr1", 32'(rom_addr), 32'd1); chk("t1_v1", 32'(pcm_valid), 32'd0);
    cyc(); chk("t1_addr2", 32'(rom_addr), 32'd2); chk("t1_v2", 32'(pcm_valid), 32'd1);
    chk("t1_pcm0", 32'(pcm_out), 32'h0000);
    cyc(); chk("t1_addr3", 32'(rom_addr), 32'd3); chk("t1_v3", 32'(pcm_valid), 32'd1);
    chk("t1_pcm1", 32'(pcm_out), 32'h0323);
    sample_tick = 1'b0;
    cyc(); chk("t1_v4", 32'(pcm_valid), 32'd1); chk("t1_pcm2", 32'(pcm_out), 32'h1001);
    chk("t1_hold", 32'(rom_addr), 32'd3);
    cyc(); chk("t1_v5", 32'(pcm_valid), 32'd1); chk("t1_pcm3", 32'(pcm_out), 32'h1002);
    cyc(); chk("t1_v6", 32'(pcm_valid), 32'd0); chk("t1_pcmh", 32'(pcm_out), 32'h1002);

    // stop with nothing in flight: DRAIN lasts exactly one cycle
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("dr_busy", 32'(busy), 32'd1); chk("dr_state", 32'(state_dbg), 32'd2);
    cyc(); chk("dr_idle", 32'(busy), 32'd0);

    // 2: offset only
    start = 1'b1; cyc(); start = 1'b0;
    sample_tick = 1'b1; fccw = '0; focw = 30'd1 << 28;
    cyc(); sample_tick = 1'b0;
    chk("t2_addr", 32'(rom_addr), 32'd64);
    cyc(); chk("t2_v0", 32'(pcm_valid), 32'd0);
    cyc(); chk("t2_v1", 32'(pcm_valid), 32'd1); chk("t2_pcm", 32'(pcm_out), 32'h7FFE);

    // 3: large increment with wrap
    fccw = 30'd3 << 28; focw = '0; sample_tick = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) sample_tick = 1'b0;
      cyc();
      if (i < 5) chk("t3_addr", 32'(rom_addr), 32'(exp_addr3[i]));
      if (i >= 2) begin
        chk("t3_valid", 32'(pcm_valid), 32'd1);
        chk("t3_pcm", 32'(pcm_out), 32'(exp_pcm3[i-2]));
      end else begin
        chk("t3_nov", 32'(pcm_valid), 32'd0);
      end
    end

    // 4: stop coincident with a tick; post-stop tick ignored
    fccw = '0; focw = '0; amp = 16'h4000;
    sample_tick = 1'b1; cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t4_drain", 32'(state_dbg), 32'd2);
    focw = 30'd1 << 28; cyc(); sample_tick = 1'b0;
    chk("t4_addr", 32'(rom_addr), 32'd192);
    chk("t4_v0", 32'(pcm_valid), 32'd1); chk("t4_pcm0", 32'(pcm_out), 32'hC000);
    cyc(); chk("t4_v1", 32'(pcm_valid), 32'd1); chk("t4_pcm1", 32'(pcm_out), 32'hC000);
    chk("t4_busy1", 32'(busy), 32'd1);
    cyc(); chk("t4_v2", 32'(pcm_valid), 32'd0); chk("t4_busy0", 32'(busy), 32'd0);

    // 5: reset while ticks are in flight
    amp = 16'h7FFF; focw = '0; fccw = 30'd1 << 22;
    start = 1'b1; cyc(); start = 1'b0;
    sample_tick = 1'b1; cyc(); cyc();
    chk("t5_pre", 32'(rom_addr), 32'd1);
    sample_tick = 1'b0; reset = 1'b1; cyc(); reset = 1'b0;
    chk("t5_valid", 32'(pcm_valid), 32'd0);
    chk("t5_addr",  32'(rom_addr),  32'd0);
    chk("t5_pcm",   32'(pcm_out),   32'd0);
    chk("t5_busy",  32'(busy),      32'd0);
    chk("t5_state", 32'(state_dbg), 32'd0);
    cyc(); chk("t5_nv0", 32'(pcm_valid), 32'd0);
    cyc(); chk("t5_nv1", 32'(pcm_valid), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    sample_tick = 1'b1;
    cyc(); chk("t5_re0", 32'(rom_addr), 32'd0);
    cyc(); chk("t5_re1", 32'(rom_addr), 32'd1);
    sample_tick = 1'b0; cyc(); cyc();
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
    chk("t5_idle", 32'(busy), 32'd0);

    // 6: start+stop in IDLE, ticks in IDLE, saturation
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("t6_ss_busy", 32'(busy), 32'd0);
    sample_tick = 1'b1; focw = 30'd1 << 28;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_idle_v", 32'(pcm_valid), 32'd0);
      chk("t6_idle_b", 32'(busy), 32'd0);
      chk("t6_idle_a", 32'(rom_addr), 32'd1);
    end
    sample_tick = 1'b0; focw = '0;
    start = 1'b1; cyc(); start = 1'b0;
    force_rom = 1'b1; amp = 16'h8000; sample_tick = 1'b1;
    cyc(); sample_tick = 1'b0;
    cyc(); cyc();
    chk("t6_sat_v", 32'(pcm_valid), 32'd1);
    chk("t6_sat",   32'(pcm_out),   32'h7FFF);
    force_rom = 1'b0;
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("t6_addr1", 32'(rom_addr), 32'd1);
    cyc(); cyc();
    chk("t6_neg", 32'(pcm_out), 32'hFCDC);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t6_dr", 32'(busy), 32'd1);
    cyc(); chk("t6_end", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
